// File: rtl/wb_slave_mem_pkg.sv
// Shared encodings for the Wishbone slave memory: FSM states and pending termination codes.
package wb_slave_mem_pkg;

    typedef enum logic [1:0] {
        WBS_IDLE = 2'd0,
        WBS_WAIT = 2'd1,
        WBS_RESP = 2'd2
    } wbs_state_e;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } rsp_e;

endpackage

// File: rtl/wb_slave_ram.sv
// Word-wide RAM with per-byte write enables: synchronous write, asynchronous read, no reset.
module wb_slave_ram #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DWIDTH/8-1:0]   sel,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH-1:0]     rdata
);

    logic [DWIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DWIDTH/8; b++) begin
                if (sel[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave RAM with byte-lane writes and programmable wait states.
// Define WB_SLV_RTY_EN to answer accesses arriving shortly after a write with rty_o.
module wb_slave_mem
    import wb_slave_mem_pkg::*;
#(
    parameter int                DWIDTH      = 32,
    parameter int                AWIDTH      = 32,
    parameter int                DEPTH_LOG2  = 6,
    parameter logic [AWIDTH-1:0] BASE_ADR    = '0,
    parameter int                WAIT_STATES = 1,
    parameter int                RTY_HOLDOFF = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AWIDTH-1:0]   adr_i,
    input  logic [DWIDTH-1:0]   dat_i,
    output logic [DWIDTH-1:0]   dat_o,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [DWIDTH/8-1:0] sel_i,
    output logic                ack_o,
    output logic                err_o,
    output logic                rty_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    wbs_state_e            state_q, state_d;
    rsp_e                  rsp_q, rsp_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  we_q, we_d;
    logic                  enter_resp;
    logic                  holdoff_busy;
    logic                  ram_we;
    logic [DWIDTH-1:0]     ram_rdata;

    wire go     = cyc_i & stb_i;
    wire adr_ok = (adr_i[1:0] == 2'b00) &&
                  (adr_i[AWIDTH-1:DEPTH_LOG2+2] == BASE_ADR[AWIDTH-1:DEPTH_LOG2+2]);

    always_comb begin
        state_d    = state_q;
        rsp_d      = rsp_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        enter_resp = 1'b0;
        case (state_q)
            WBS_IDLE: begin
                if (go) begin
                    idx_d = adr_i[DEPTH_LOG2+1:2];
                    we_d  = we_i;
                    if (!adr_ok) begin
                        rsp_d      = RSP_ERR;
                        state_d    = WBS_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        rsp_d = holdoff_busy ? RSP_RTY : RSP_ACK;
                        if (WS == 4'd0) begin
                            state_d    = WBS_RESP;
                            enter_resp = 1'b1;
                        end else begin
                            wcnt_d  = WS;
                            state_d = WBS_WAIT;
                        end
                    end
                end
            end
            WBS_WAIT: begin
                // A master that withdraws mid-wait gets no termination and no side effects.
                if (!go) begin
                    state_d = WBS_IDLE;
                end else if (wcnt_q == 4'd1) begin
                    state_d    = WBS_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            WBS_RESP: state_d = WBS_IDLE;
            default:  state_d = WBS_IDLE;
        endcase
    end

    // Write data and lanes are taken live on the edge entering RESP, while inputs are still valid.
    assign ram_we = enter_resp && (rsp_d == RSP_ACK) && we_d;

    wb_slave_ram #(
        .DWIDTH    (DWIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .sel  (sel_i),
        .addr (idx_d),
        .wdata(dat_i),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WBS_IDLE;
            rsp_q   <= RSP_ACK;
            wcnt_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            ack_o   <= enter_resp && (rsp_d == RSP_ACK);
            err_o   <= enter_resp && (rsp_d == RSP_ERR);
            dat_o   <= (enter_resp && (rsp_d == RSP_ACK) && !we_d) ? ram_rdata : '0;
        end
    end

`ifdef WB_SLV_RTY_EN
    localparam logic [15:0] HOLD = 16'(RTY_HOLDOFF);

    logic [15:0] hcnt_q;
    logic        rty_q;

    assign holdoff_busy = (hcnt_q != 16'd0);
    assign rty_o        = rty_q;

    // Only acked writes arm the holdoff; retried accesses let it keep draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            rty_q  <= 1'b0;
        end else begin
            rty_q <= enter_resp && (rsp_d == RSP_RTY);
            if (ram_we)
                hcnt_q <= HOLD;
            else if (hcnt_q != 16'd0)
                hcnt_q <= hcnt_q - 16'd1;
        end
    end
`else
    assign holdoff_busy = 1'b0;
    assign rty_o        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: driver queues expected terminations, a negedge monitor checks them.
module tb_wb_slave_mem;

    localparam int WS = 3;
    localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_RTY = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic        ack_o, err_o, rty_o;

    wb_slave_mem #(
        .DWIDTH     (32),
        .AWIDTH     (32),
        .DEPTH_LOG2 (6),
        .BASE_ADR   (32'h0),
        .WAIT_STATES(WS),
        .RTY_HOLDOFF(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .adr_i(adr_i),
        .dat_i(dat_i),
        .dat_o(dat_o),
        .cyc_i(cyc_i),
        .stb_i(stb_i),
        .we_i (we_i),
        .sel_i(sel_i),
        .ack_o(ack_o),
        .err_o(err_o),
        .rty_o(rty_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: every termination must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (ack_o || err_o || rty_o)) begin
            logic [1:0] k;
            exp_t       e;
            k = ack_o ? K_ACK : (err_o ? K_ERR : K_RTY);
            check("term_onehot", 32'(ack_o) + 32'(err_o) + 32'(rty_o), 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: got kind %0d with no pending access (cycle %0d)", k, cyc_cnt);
            end else begin
                e = sb.pop_front();
                check("term_kind", 32'(k), 32'(e.kind));
                check("term_data", dat_o, e.data);
                check("term_cycle", 32'(cyc_cnt), 32'(e.at));
            end
        end
    end

    task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, input logic [1:0] kind, input logic [31:0] edata);
        bit seen = 0;
        @(negedge clk);
        adr_i = adr; dat_i = dat; we_i = we; sel_i = sel;
        cyc_i = 1'b1; stb_i = 1'b1;
        sb.push_back('{kind: kind, data: edata, at: cyc_cnt + 1 + ((kind == K_ERR) ? 0 : WS)});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_o || err_o || rty_o) begin
                seen = 1;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no termination for adr %h, expected kind %0d", adr, kind);
            void'(sb.pop_back());
        end
    endtask

    // Writes leave a gap so the retry holdoff never hides a later ack.
    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic [1:0] kind);
        access(adr, dat, 1'b1, sel, kind, 32'h0);
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [1:0] kind, input logic [31:0] edata);
        access(adr, 32'h0, 1'b0, 4'hF, kind, edata);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_rty", 32'(rty_o), 32'd0);
        check("reset_dat", dat_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Full-word write/read round trip, read ignores sel
        wr(32'h10, 32'hDEADBEEF, 4'hF, K_ACK);
        rd(32'h10, K_ACK, 32'hDEADBEEF);
        access(32'h10, 32'h0, 1'b0, 4'h0, K_ACK, 32'hDEADBEEF);

        // Partial-lane write
        wr(32'h20, 32'h11223344, 4'hF, K_ACK);
        wr(32'h20, 32'hAABBCCDD, 4'b0101, K_ACK);
        rd(32'h20, K_ACK, 32'h11BB33DD);

        // Address decode errors, including writes that alias word 0 / word 0 bytes
        wr(32'h00, 32'hCAFEF00D, 4'hF, K_ACK);
        rd(32'h100, K_ERR, 32'h0);
        rd(32'h02, K_ERR, 32'h0);
        wr(32'h100, 32'h12345678, 4'hF, K_ERR);
        wr(32'h02, 32'h87654321, 4'hF, K_ERR);
        rd(32'h00, K_ACK, 32'hCAFEF00D);
        wr(32'hFC, 32'h5A5A00FF, 4'hF, K_ACK);
        rd(32'hFC, K_ACK, 32'h5A5A00FF);

        // Aborted write: cyc dropped two cycles into the wait
        wr(32'h04, 32'h0BADF00D, 4'hF, K_ACK);
        @(negedge clk);
        adr_i = 32'h04; dat_i = 32'hFFFFFFFF; we_i = 1'b1; sel_i = 4'hF;
        cyc_i = 1'b1; stb_i = 1'b1;
        repeat (2) @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        repeat (8) @(negedge clk);
        rd(32'h04, K_ACK, 32'h0BADF00D);

        // Reset in the middle of a wait: no termination, next access is clean
        @(negedge clk);
        adr_i = 32'h10; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_wait_ack", 32'(ack_o), 32'd0);
        check("rst_wait_dat", dat_o, 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd(32'h20, K_ACK, 32'h11BB33DD);

        // Reset while ack is being presented clears outputs immediately
        @(negedge clk);
        sb.push_back('{kind: K_ACK, data: 32'hDEADBEEF, at: cyc_cnt + 1 + WS});
        adr_i = 32'h10; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        repeat (WS + 1) @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_resp_ack", 32'(ack_o), 32'd0);
        check("rst_resp_dat", dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

`ifdef WB_SLV_RTY_EN
        // Read right behind a write is retried; after the holdoff it completes
        access(32'h30, 32'h13579BDF, 1'b1, 4'hF, K_ACK, 32'h0);
        rd(32'h30, K_RTY, 32'h0);
        repeat (4) @(negedge clk);
        rd(32'h30, K_ACK, 32'h13579BDF);
`endif

        repeat (10) @(negedge clk);
        check("pending_terms", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
